imu_burst_reader: RTL and testbench

- Parametrised successor to the single-register IMU reader.
- Writes a parameter-defined table of configuration registers over 4-wire SPI (mode 3), then repeatedly performs one multi-byte burst read (CS held low, device address auto-increment) at a fixed sample rate.
- Presents the assembled sample on a valid/ready handshake to downstream logic, e.g. the orientation/display path.
- Contains its own SPI shift engine with a programmable SPC divider.

---
 rtl/imu_burst_reader.sv | 246 ++++++++++++++++++++++++
 tb/tb_imu_burst_reader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_burst_reader.sv
// IMU burst reader: writes a table of config registers over 4-wire SPI
// (mode 3), then repeatedly burst-reads N_BYTES starting at BASE_ADDR.
// Latency: a sample is published one cycle after the burst CS rise.
// Backpressure: valid/ready output; an unconsumed sample is overwritten
// by the next one and counted in overrun_cnt (saturating).
//
// Ports:
//   clk, reset       system clock, synchronous active-low reset
//   enable           gates the start of new bursts (in-flight burst completes)
//   SDO / SPC/CS/SDI SPI lines (SPC idles high, CS active low)
//   data/data_valid/data_ready  sample handshake, data[7:0] = byte at BASE_ADDR
//   cfg_done         configuration table written
//   overrun_cnt      count of samples overwritten before being consumed
module imu_burst_reader #(
    parameter int                 CLK_DIV       = 4,
    parameter int                 N_CFG         = 4,
    parameter logic [N_CFG*8-1:0] CFG_ADDR      = {8'h18, 8'h13, 8'h11, 8'h10},
    parameter logic [N_CFG*8-1:0] CFG_DATA      = {8'hE2, 8'h04, 8'h50, 8'h50},
    parameter logic [7:0]         BASE_ADDR     = 8'h22,
    parameter int                 N_BYTES       = 12,
    parameter int                 SAMPLE_PERIOD = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 SDO,
    output logic                 SPC,
    output logic                 CS,
    output logic                 SDI,
    output logic [N_BYTES*8-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 cfg_done,
    output logic [7:0]           overrun_cnt
);

    localparam int TXW = 8 + 8 * N_BYTES;   // longest frame (burst), bits
    localparam int RXW = 8 * N_BYTES;
    localparam int CW  = $clog2(2 * CLK_DIV - 1) + 1;
    localparam int HW  = $clog2(2 * TXW) + 1;
    localparam int WW  = $clog2(SAMPLE_PERIOD) + 1;
    localparam int EW  = $clog2(N_CFG) + 1;

    localparam logic [CW-1:0] DIV_LAST        = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST        = CW'(2 * CLK_DIV - 1);
    localparam logic [HW-1:0] CFG_HALF_LAST   = HW'(32);
    localparam logic [HW-1:0] BURST_HALF_LAST = HW'(2 * TXW);
    localparam logic [WW-1:0] WAIT_LAST       = WW'(SAMPLE_PERIOD - 1);
    localparam logic [EW-1:0] ENTRY_LAST      = EW'(N_CFG - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_CFG_XFER,
        ST_CFG_GAP,
        ST_WAIT,
        ST_BURST_XFER,
        ST_BURST_GAP
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;     // cycles within a half-period / gap
    logic [HW-1:0]    r_half, w_half_nxt;   // SPC half-period index in a frame
    logic [EW-1:0]    r_entry, w_entry_nxt;
    logic [WW-1:0]    r_wait, w_wait_nxt;
    logic [TXW-1:0]   r_tx;
    logic [RXW-1:0]   r_rx;
    logic             r_cs, r_spc, r_sdi;
    logic [RXW-1:0]   r_data;
    logic             r_valid, r_cfg_done;
    logic [7:0]       r_overrun;

    logic             w_load_cfg, w_load_burst;
    logic             w_xfer_nxt, w_shift_tx, w_sample, w_publish;
    logic [HW-1:0]    w_half_last;
    logic [6:0]       w_cfg_addr;
    logic [7:0]       w_cfg_data;
    logic [TXW-1:0]   w_tx_cfg, w_tx_burst;
    logic [RXW-1:0]   w_rx_le;

    assign w_half_last = (r_state == ST_CFG_XFER) ? CFG_HALF_LAST : BURST_HALF_LAST;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_half_nxt   = r_half;
        w_entry_nxt  = r_entry;
        // Saturate so a long enable=0 hold never wraps the period counter.
        w_wait_nxt   = (r_wait < WAIT_LAST) ? r_wait + 1'b1 : r_wait;
        w_load_cfg   = 1'b0;
        w_load_burst = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = ST_CFG_XFER;
                    w_cnt_nxt   = '0;
                    w_half_nxt  = '0;
                    w_load_cfg  = 1'b1;
                end
            end
            ST_CFG_XFER, ST_BURST_XFER: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_half == w_half_last) begin
                        // CS rises here; the period counter starts from the burst CS rise.
                        w_state_nxt = (r_state == ST_CFG_XFER) ? ST_CFG_GAP : ST_BURST_GAP;
                        w_half_nxt  = '0;
                        if (r_state == ST_BURST_XFER)
                            w_wait_nxt = '0;
                    end else begin
                        w_half_nxt = r_half + 1'b1;
                    end
                end
            end
            ST_CFG_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_entry == ENTRY_LAST) begin
                        w_state_nxt = ST_WAIT;
                        w_wait_nxt  = '0;
                    end else begin
                        w_entry_nxt = r_entry + 1'b1;
                        w_state_nxt = ST_CFG_XFER;
                        w_half_nxt  = '0;
                        w_load_cfg  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = '0;
                if (r_wait >= WAIT_LAST && enable) begin
                    w_state_nxt  = ST_BURST_XFER;
                    w_half_nxt   = '0;
                    w_load_burst = 1'b1;
                end
            end
            ST_BURST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Table lookup for the entry about to be sent; entry 0 is the MSB byte.
    always_comb begin
        w_cfg_addr = '0;
        w_cfg_data = '0;
        for (int i = 0; i < N_CFG; i++) begin
            if (w_entry_nxt == EW'(i)) begin
                w_cfg_addr = CFG_ADDR[8*(N_CFG-1-i) +: 7];
                w_cfg_data = CFG_DATA[8*(N_CFG-1-i) +: 8];
            end
        end
    end

    // Frames are MSB-aligned in r_tx; burst data bytes shift out as zeros.
    assign w_tx_cfg   = TXW'({1'b0, w_cfg_addr, w_cfg_data}) << (TXW - 16);
    assign w_tx_burst = TXW'({1'b1, BASE_ADDR[6:0]}) << (TXW - 8);

    // First received byte lands at the top of r_rx; publish it as data[7:0].
    always_comb begin
        w_rx_le = '0;
        for (int k = 0; k < N_BYTES; k++)
            w_rx_le[8*k +: 8] = r_rx[8*(N_BYTES-1-k) +: 8];
    end

    assign w_xfer_nxt = (w_state_nxt == ST_CFG_XFER) || (w_state_nxt == ST_BURST_XFER);
    // Odd half-periods are SPC low; SDI changes on their first cycle.
    assign w_shift_tx = w_xfer_nxt && w_half_nxt[0] && (w_cnt_nxt == '0);
    // SDO captured in the first cycle SPC is high again after a bit (half > 0, even).
    assign w_sample   = (r_state == ST_BURST_XFER) && (r_cnt == '0) &&
                        (r_half != '0) && !r_half[0];
    assign w_publish  = (r_state == ST_BURST_GAP) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_INIT;
            r_cnt      <= '0;
            r_half     <= '0;
            r_entry    <= '0;
            r_wait     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cs       <= 1'b1;
            r_spc      <= 1'b1;
            r_sdi      <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_cfg_done <= 1'b0;
            r_overrun  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_half  <= w_half_nxt;
            r_entry <= w_entry_nxt;
            r_wait  <= w_wait_nxt;

            // SPI pins are registered from next-state so they never glitch.
            r_cs  <= !w_xfer_nxt;
            r_spc <= !(w_xfer_nxt && w_half_nxt[0]);

            if (w_load_cfg)
                r_tx <= w_tx_cfg;
            else if (w_load_burst)
                r_tx <= w_tx_burst;
            else if (w_shift_tx)
                r_tx <= r_tx << 1;

            if (w_shift_tx)
                r_sdi <= r_tx[TXW-1];
            else if (!w_xfer_nxt)
                r_sdi <= 1'b0;

            // Address-phase bits shift out of the top of r_rx before data completes.
            if (w_sample)
                r_rx <= {r_rx[RXW-2:0], SDO};

            if (r_state == ST_CFG_GAP && w_state_nxt == ST_WAIT)
                r_cfg_done <= 1'b1;

            if (w_publish) begin
                r_data  <= w_rx_le;
                r_valid <= 1'b1;
                // A handshake in the publish cycle consumed the old sample.
                if (r_valid && !data_ready && r_overrun != 8'hFF)
                    r_overrun <= r_overrun + 8'd1;
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign SPC         = r_spc;
    assign CS          = r_cs;
    assign SDI         = r_sdi;
    assign data        = r_data;
    assign data_valid  = r_valid;
    assign cfg_done    = r_cfg_done;
    assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_imu_burst_reader.sv
// Directed bench for imu_burst_reader with CLK_DIV=2, SAMPLE_PERIOD=50.
// A behavioural SPI device records each frame's first 16 SDI bits and
// returns bytes (burst_index*16 + k + 1) during burst reads.
module tb_imu_burst_reader;

    localparam int CD = 2;
    localparam int NB = 12;
    localparam int SP = 50;
    localparam int CFG_LOW   = CD * (2 * 16 + 1);          // 66
    localparam int BURST_LOW = CD * (2 * (8 + 8 * NB) + 1); // 418

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          SDO = 1'b0;
    logic          SPC, CS, SDI;
    logic [NB*8-1:0] data;
    logic          data_valid;
    logic          data_ready;
    logic          cfg_done;
    logic [7:0]    overrun_cnt;

    always #5 clk = ~clk;

    imu_burst_reader #(
        .CLK_DIV       (CD),
        .N_BYTES       (NB),
        .SAMPLE_PERIOD (SP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .SDO         (SDO),
        .SPC         (SPC),
        .CS          (CS),
        .SDI         (SDI),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .cfg_done    (cfg_done),
        .overrun_cnt (overrun_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pin monitor, sampled mid-cycle.
    int   cyc = 0;
    logic prev_cs = 1'b1, prev_spc = 1'b1, prev_done = 1'b0;
    bit   spc_armed = 0;
    int   fall_q[$], rise_q[$], spcf_q[$];
    int   done_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (CS === 1'b0 && prev_cs === 1'b1) begin
            fall_q.push_back(cyc);
            spc_armed = 1;
        end
        if (CS === 1'b1 && prev_cs === 1'b0)
            rise_q.push_back(cyc);
        if (spc_armed && SPC === 1'b0 && prev_spc === 1'b1) begin
            spcf_q.push_back(cyc);
            spc_armed = 0;
        end
        if (cfg_done === 1'b1 && prev_done !== 1'b1)
            done_cyc = cyc;
        prev_cs   = CS;
        prev_spc  = SPC;
        prev_done = cfg_done;
    end

    // SPI device model (mode 3).
    logic [15:0] dev_hdr = '0;
    logic [7:0]  dev_byte;
    int          dev_bits = 0, dev_falls = 0, dev_bursts = 0;
    logic [15:0] fr_hdr_q[$];
    int          fr_bits_q[$];

    always @(negedge CS) begin
        dev_hdr   = '0;
        dev_bits  = 0;
        dev_falls = 0;
    end

    always @(posedge SPC) begin
        if (CS === 1'b0) begin
            if (dev_bits < 16)
                dev_hdr = {dev_hdr[14:0], SDI};
            dev_bits++;
        end
    end

    always @(negedge SPC) begin
        if (CS === 1'b0) begin
            if (dev_falls >= 8) begin
                dev_byte = 8'(dev_bursts * 16 + (dev_falls - 8) / 8 + 1);
                SDO = dev_byte[7 - ((dev_falls - 8) % 8)];
            end else begin
                SDO = 1'b0;
            end
            dev_falls++;
        end
    end

    always @(posedge CS) begin
        fr_hdr_q.push_back(dev_hdr);
        fr_bits_q.push_back(dev_bits);
        if (dev_hdr[15] === 1'b1)
            dev_bursts++;
    end

    function automatic logic [NB*8-1:0] exp_sample(input int n);
        logic [NB*8-1:0] r;
        for (int k = 0; k < NB; k++)
            r[8*k +: 8] = 8'(n * 16 + k + 1);
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fall(input int n, input string tag);
        int t = 0;
        while (fall_q.size() <= n && t < 3000) begin tick(); t++; end
        check({"wait_fall_", tag}, fall_q.size() > n, 1'b1);
    endtask

    task automatic wait_rise(input int n, input string tag);
        int t = 0;
        while (rise_q.size() <= n && t < 3000) begin tick(); t++; end
        check({"wait_rise_", tag}, rise_q.size() > n, 1'b1);
    endtask

    task automatic wait_frames(input int n, input string tag);
        int t = 0;
        while (fr_hdr_q.size() <= n && t < 3000) begin tick(); t++; end
        check({"wait_frame_", tag}, fr_hdr_q.size() > n, 1'b1);
    endtask

    logic [15:0] cfg_exp [4] = '{16'h18E2, 16'h1304, 16'h1150, 16'h1050};

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fb, rb, hb, sb, nf, en_cyc, idx;
        reset = 1'b0;
        enable = 1'b1;
        data_ready = 1'b0;
        repeat (3) tick();

        check("rst_cs", CS, 1'b1);
        check("rst_spc", SPC, 1'b1);
        check("rst_sdi", SDI, 1'b0);
        check("rst_data", data, '0);
        check("rst_valid", data_valid, 1'b0);
        check("rst_cfg_done", cfg_done, 1'b0);
        check("rst_overrun", overrun_cnt, 8'd0);

        fb = fall_q.size();
        rb = rise_q.size();
        hb = fr_hdr_q.size();
        sb = spcf_q.size();
        reset = 1'b1;

        // Configuration frames, timing and cfg_done.
        wait_rise(rb + 3, "cfg");
        repeat (6) tick();
        for (int i = 0; i < 4; i++) begin
            check("cfg_frame", fr_hdr_q[hb + i], cfg_exp[i]);
            check("cfg_bits", fr_bits_q[hb + i], 16);
            check("cfg_cs_low", rise_q[rb + i] - fall_q[fb + i], CFG_LOW);
            if (i < 3)
                check("cfg_gap", fall_q[fb + i + 1] - rise_q[rb + i], 2 * CD);
        end
        check("spc_first_fall", spcf_q[sb] - fall_q[fb], CD);
        check("cfg_done_set", cfg_done, 1'b1);
        check("cfg_done_time", done_cyc - rise_q[rb + 3], 2 * CD);

        // Burst 0: header, length, publish one cycle after CS rise.
        wait_rise(rb + 4, "b0");
        check("b0_valid_at_rise", data_valid, 1'b0);
        tick();
        check("b0_valid", data_valid, 1'b1);
        check("b0_data", data, exp_sample(0));
        check("b0_hdr", fr_hdr_q[hb + 4], 16'hA200);
        check("b0_bits", fr_bits_q[hb + 4], 8 + 8 * NB);
        check("b0_start", fall_q[fb + 4] - done_cyc, SP);
        check("b0_cs_low", rise_q[rb + 4] - fall_q[fb + 4], BURST_LOW);

        // Bursts 1 and 2 unconsumed -> overruns.
        wait_rise(rb + 5, "b1");
        tick();
        check("b1_overrun", overrun_cnt, 8'd1);
        check("b1_data", data, exp_sample(1));
        check("b1_period", fall_q[fb + 5] - fall_q[fb + 4], SP + BURST_LOW);
        wait_rise(rb + 6, "b2");
        tick();
        check("b2_overrun", overrun_cnt, 8'd2);
        check("b2_data", data, exp_sample(2));
        check("b2_valid", data_valid, 1'b1);

        // Single-cycle consume.
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        tick();
        check("hs_valid_clear", data_valid, 1'b0);
        check("hs_overrun", overrun_cnt, 8'd2);

        // Burst 3 publishes into an empty slot.
        wait_rise(rb + 7, "b3");
        tick();
        check("b3_valid", data_valid, 1'b1);
        check("b3_data", data, exp_sample(3));
        check("b3_overrun", overrun_cnt, 8'd2);

        // Burst 4: ready high in the CS-rise cycle, coinciding with publish.
        wait_rise(rb + 8, "b4");
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("b4_valid", data_valid, 1'b1);
        check("b4_data", data, exp_sample(4));
        check("b4_overrun", overrun_cnt, 8'd2);
        tick();
        check("b4_valid_hold", data_valid, 1'b1);

        // enable dropped mid-burst: burst 5 completes, then no new bursts.
        wait_fall(fb + 9, "b5");
        repeat (100) tick();
        enable = 1'b0;
        wait_rise(rb + 9, "b5");
        tick();
        check("b5_data", data, exp_sample(5));
        check("b5_overrun", overrun_cnt, 8'd3);
        nf = fall_q.size();
        repeat (1000) tick();
        check("en_hold", fall_q.size(), nf);
        enable = 1'b1;
        en_cyc = cyc;
        wait_fall(fb + 10, "b6");
        check("en_resume", (fall_q[fb + 10] - en_cyc) <= SP, 1'b1);

        // Reset during bit 40 of burst 6.
        repeat (2 * CD * 40 + CD + 1) tick();
        reset = 1'b0;
        tick();
        check("mrst_cs", CS, 1'b1);
        check("mrst_spc", SPC, 1'b1);
        check("mrst_valid", data_valid, 1'b0);
        check("mrst_cfg_done", cfg_done, 1'b0);
        check("mrst_overrun", overrun_cnt, 8'd0);
        check("mrst_data", data, '0);
        reset = 1'b1;
        idx = fr_hdr_q.size();
        wait_frames(idx + 3, "recfg");
        for (int i = 0; i < 4; i++)
            check("recfg_frame", fr_hdr_q[idx + i], cfg_exp[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
